// File: rtl/popcount_pkg.sv
// Shared widths and types for the 64-bit population counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// DATA_W / CNT_W fix the datapath. The intermediate widths name each level
// of the adder tree. Each level is one bit wider than the level it sums,
// which is enough to hold the largest possible sum, so no level can overflow.
package popcount_pkg;

  localparam int DATA_W    = 64;
  localparam int CNT_W     = 7;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = DATA_W / BYTE_W;  // 8 leaf counters

  localparam int L0_W      = 4;  // per-byte count, 0..8
  localparam int L1_W      = 5;  // pair of bytes, 0..16
  localparam int L2_W      = 6;  // four bytes,    0..32
  localparam int L3_W      = 7;  // full word,     0..64

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [L0_W-1:0]   l0_t;
  typedef logic [L1_W-1:0]   l1_t;
  typedef logic [L2_W-1:0]   l2_t;
  typedef logic [L3_W-1:0]   l3_t;

  // Each helper zero-extends both operands to the result width before adding.
  function automatic l1_t add_l0(input l0_t a, input l0_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic l2_t add_l1(input l1_t a, input l1_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic l3_t add_l2(input l2_t a, input l2_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/popcount_popcount8.sv
// Combinational count of the set bits in one byte.
// Latency: 0 cycles (purely combinational).
// Backpressure: none. The output follows the input.
//
// Ports:
//   in  - byte to count
//   cnt - number of ones in the byte, 0..8
module popcount8
  import popcount_pkg::*;
(
  input  logic [BYTE_W-1:0] in,
  output logic [L0_W-1:0]   cnt
);

  // Split the byte into two nibbles and count each nibble as a sum of its
  // bits. This gives shallow logic that maps well onto LUT4/LUT6 fabrics.
  logic [2:0] lo_cnt;
  logic [2:0] hi_cnt;

  always_comb begin
    lo_cnt = 3'd0;
    hi_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      lo_cnt = lo_cnt + {2'b00, in[i]};
      hi_cnt = hi_cnt + {2'b00, in[i+4]};
    end
  end

  assign cnt = {1'b0, lo_cnt} + {1'b0, hi_cnt};

endmodule

// File: rtl/popcount_64.sv
// Registered 64-bit population counter with a fixed adder tree.
// Latency: 1 cycle. The word sampled at edge N is counted on out after edge N.
// Backpressure: none. A new word is accepted on every cycle.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear of the output register
//   in    - 64-bit word, sampled every rising edge
//   out   - count of set bits in the last sampled word, 0..64
module popcount_64
  import popcount_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  output logic [CNT_W-1:0]  out
);

  l0_t   byte_cnt [NUM_BYTES];
  l1_t   sum_l1   [NUM_BYTES/2];
  l2_t   sum_l2   [NUM_BYTES/4];
  l3_t   sum_l3;
  cnt_t  out_q;

  // Leaf level: one byte counter per byte lane.
  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
    popcount8 u_pc8 (
      .in  (in[b*BYTE_W +: BYTE_W]),
      .cnt (byte_cnt[b])
    );
  end

  // Three-level balanced tree: 8 -> 4 -> 2 -> 1.
  for (genvar i = 0; i < NUM_BYTES/2; i++) begin : g_l1
    assign sum_l1[i] = add_l0(byte_cnt[2*i], byte_cnt[2*i+1]);
  end

  for (genvar i = 0; i < NUM_BYTES/4; i++) begin : g_l2
    assign sum_l2[i] = add_l1(sum_l1[2*i], sum_l1[2*i+1]);
  end

  assign sum_l3 = add_l2(sum_l2[0], sum_l2[1]);

  // This is the only register in the block. The tree ahead of it is
  // combinational from the input pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= cnt_t'(sum_l3);
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_popcount_64.sv
module tb_popcount_64;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_word;
  logic [6:0]  out_cnt;

  int chk_cnt;
  int pass_cnt;

  popcount_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_word),
    .out   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit-by-bit loop, independent of the RTL tree.
  function automatic logic [6:0] ref_count(input logic [63:0] w);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (w[i]) c = c + 7'd1;
    end
    return c;
  endfunction

  // Applies a word between edges, then waits for the next edge and samples 1 ns later.
  task automatic apply_and_sample(input logic [63:0] w);
    in_word = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    in_word = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk_cnt++;
    if (out_cnt !== 7'd0) $display("FAIL reset_initial: out=%0d expected=0", out_cnt);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if (out_cnt !== 7'd0) $display("FAIL reset_hold_%0d: out=%0d expected=0", c, out_cnt);
      else pass_cnt++;
    end
    in_word = 64'h0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_cnt !== 7'd0) $display("FAIL reset_release: out=%0d expected=0", out_cnt);
    else pass_cnt++;
  endtask

  task automatic test_small;
    logic [63:0] vin [3];
    logic [6:0]  vexp[3];
    vin[0] = 64'd1; vexp[0] = 7'd1;
    vin[1] = 64'd2; vexp[1] = 7'd1;
    vin[2] = 64'd3; vexp[2] = 7'd2;
    for (int i = 0; i < 3; i++) begin
      apply_and_sample(vin[i]);
      chk_cnt++;
      if (out_cnt !== vexp[i])
        $display("FAIL small_%0d: in=%h out=%0d expected=%0d", i, vin[i], out_cnt, vexp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_patterns;
    logic [63:0] vin [5];
    logic [6:0]  vexp[5];
    vin[0] = 64'hFFFF_FFFF_FFFF_FFFF; vexp[0] = 7'd64;
    vin[1] = 64'hAAAA_AAAA_AAAA_AAAA; vexp[1] = 7'd32;
    vin[2] = 64'h8000_0000_0000_0001; vexp[2] = 7'd2;
    vin[3] = 64'h0000_0000_0000_00FF; vexp[3] = 7'd8;
    vin[4] = 64'h0102_0408_1020_4080; vexp[4] = 7'd8;
    for (int i = 0; i < 5; i++) begin
      apply_and_sample(vin[i]);
      chk_cnt++;
      if (out_cnt !== vexp[i])
        $display("FAIL pattern_%0d: in=%h out=%0d expected=%0d", i, vin[i], out_cnt, vexp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w;
    logic [6:0]  e;
    for (int i = 0; i < 8; i++) begin
      w = (i % 2 == 0) ? 64'h0 : 64'hFF00_FF00_FF00_FF00;
      e = (i % 2 == 0) ? 7'd0 : 7'd32;
      apply_and_sample(w);
      chk_cnt++;
      if (out_cnt !== e)
        $display("FAIL b2b_%0d: out=%0d expected=%0d", i, out_cnt, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    int unsigned seed;
    logic [63:0] w;
    logic [6:0]  e;
    seed = 32'd20240611;
    void'($urandom(seed));
    $display("random seed = %0d", seed);
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom};
      e = ref_count(w);
      apply_and_sample(w);
      chk_cnt++;
      if (out_cnt !== e) begin
        $display("NG  random_%0d FAIL: in=%h out=%0d expected=%0d", i, w, out_cnt, e);
      end else begin
        pass_cnt++;
        $display("OK  random_%0d: in=%h out=%0d", i, w, out_cnt);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply_and_sample(64'hFFFF_FFFF_FFFF_FFFF);
    chk_cnt++;
    if (out_cnt !== 7'd64) $display("FAIL midrst_pre: out=%0d expected=64", out_cnt);
    else pass_cnt++;
    // Mid-cycle: well clear of both the rising and falling edges.
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_cnt !== 7'd0) $display("FAIL midrst_async: out=%0d expected=0", out_cnt);
    else pass_cnt++;
    in_word = 64'h0F;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_cnt !== 7'd0) $display("FAIL midrst_held: out=%0d expected=0", out_cnt);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_cnt !== 7'd4) $display("FAIL midrst_release: out=%0d expected=4", out_cnt);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    in_word  = 64'h0;
    test_reset();
    test_small();
    test_patterns();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
